// File: rtl/mont_r2_gen.sv
// Montgomery R^2 mod P generator: 2*WIDTH sequential modular doublings of acc,
// starting from 1, give 2^(2*WIDTH) mod P for an odd modulus P > 1.
module mont_r2_gen #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] R2,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(2*WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2*WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_nxt;
  logic             p_ok;

  // acc < p_reg keeps dbl < 2*p_reg, so a negative difference always shows up
  // in the top bit and doubles as the (t >= p_reg) compare.
  assign dbl     = {acc, 1'b0};
  assign diff    = dbl - {1'b0, p_reg};
  assign acc_nxt = diff[WIDTH] ? dbl[WIDTH-1:0] : diff[WIDTH-1:0];
  assign p_ok    = P[0] && (P > WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      R2    <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p_reg <= P;
            acc   <= WIDTH'(1);
            cnt   <= '0;
            if (p_ok) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              R2    <= '0;
            end
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            R2    <= acc_nxt;
            done  <= 1'b1;
            err   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_r2_gen.sv
// Directed and random checks of mont_r2_gen against 2^(2W) mod P computed with
// plain wide arithmetic.
module tb_mont_r2_gen;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] P = '0;
  logic [W-1:0] R2;
  logic         done, busy, err;

  int nvec = 0;
  int nerr = 0;

  mont_r2_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .P(P),
    .R2(R2), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_r2(input logic [W-1:0] p);
    logic [2*W:0] big;
    logic [2*W:0] pm;
    logic [2*W:0] r;
    if (p[0] == 1'b0 || p <= 1) return '0;
    big = '0;
    big[2*W] = 1'b1;
    pm = {{(W+1){1'b0}}, p};
    r  = big % pm;
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request/acknowledge transaction; optionally changes P mid-computation.
  task automatic do_op(input string tag, input logic [W-1:0] p, input logic [W-1:0] exp_r2,
                       input logic exp_err, input int mid_at, input logic [W-1:0] p_mid);
    logic [W-1:0] r2_prev;
    int lat;
    @(negedge clk);
    start = 1'b1;
    P = p;
    r2_prev = R2;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 2*W + 20) begin
      chk({tag, "_mutex"}, W'(busy & done), '0);
      chk({tag, "_r2_hold"}, R2, r2_prev);
      chk({tag, "_busy"}, W'(busy), W'(1));
      if (lat == mid_at) P = p_mid;
      @(posedge clk); #1;
      lat++;
    end
    // invalid modulus finishes at the accepting edge itself
    chk({tag, "_latency"}, W'(lat), exp_err ? W'(0) : W'(2*W));
    chk({tag, "_done"}, W'(done), W'(1));
    chk({tag, "_busy_at_done"}, W'(busy), '0);
    chk({tag, "_err"}, W'(err), W'(exp_err));
    chk({tag, "_r2"}, R2, exp_r2);
    @(posedge clk); #1;
    chk({tag, "_done_held"}, W'(done), W'(1));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, W'(done), '0);
    chk({tag, "_err_clr"}, W'(err), '0);
    chk({tag, "_r2_idle"}, R2, exp_r2);
  endtask

  initial begin
    logic [W-1:0] pr;
    logic [W-1:0] all1;
    logic [W-1:0] p255;
    all1 = '1;
    p255 = '0;
    p255[W-1] = 1'b1;
    p255[0] = 1'b1;

    #12;
    chk("rst_r2", R2, '0);
    chk("rst_done", W'(done), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_err", W'(err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_done", W'(done), '0);

    do_op("p101", W'(101), W'(56), 1'b0, -1, '0);
    do_op("p7", W'(7), W'(4), 1'b0, -1, '0);
    do_op("p_all1", all1, W'(1), 1'b0, -1, '0);
    do_op("p255", p255, W'(4), 1'b0, 100, W'(101));
    do_op("p100", W'(100), '0, 1'b1, -1, '0);
    do_op("p1", W'(1), '0, 1'b1, -1, '0);
    do_op("p0", W'(0), '0, 1'b1, -1, '0);
    do_op("p3", W'(3), W'(1), 1'b0, -1, '0);

    // abort a computation with an asynchronous reset
    @(negedge clk);
    start = 1'b1;
    P = W'(101);
    repeat (201) @(posedge clk);
    #2;
    chk("pre_abort_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_r2", R2, '0);
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_err", W'(err), '0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (done || busy) begin
        chk("abort_quiet", W'({busy, done}), '0);
        break;
      end
    end
    chk("abort_r2_after", R2, '0);
    do_op("restart", W'(101), W'(56), 1'b0, -1, '0);

    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < W/32; j++) pr[j*32 +: 32] = $urandom;
      if (k < 5) pr = pr >> $urandom_range(W-8, 8);
      pr[0] = 1'b1;
      pr[1] = 1'b1;
      do_op($sformatf("rnd%0d", k), pr, ref_r2(pr), 1'b0, -1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
